// File: rtl/col_gen_pkg.sv
// Shared constants, types and the LFSR step for the column weight generator.
package col_gen_pkg;

   localparam int          COL_W     = 128;
   localparam int          CNT_W     = 8;
   localparam int          LFSR_W    = 16;

   // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] SEED_DEF  = 16'hACE1;

   typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
   typedef enum logic       {SET, CLEAR}       mode_t;

   // One Galois step: shift right, fold the feedback mask in when a one drops out.
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      logic [15:0] shifted;
      shifted = cur >> 1;
      return cur[0] ? (shifted ^ LFSR_TAPS) : shifted;
   endfunction

endpackage

// File: rtl/col_weight_gen_lfsr16.sv
// 16-bit Galois LFSR with seed load; a zero seed would lock the register, so it is replaced.
module lfsr16 #(
   parameter logic [15:0] SEED_DEF = col_gen_pkg::SEED_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        adv,
   output logic [15:0] state
);
   import col_gen_pkg::*;

   logic [15:0] state_q;
   logic [15:0] state_d;

   // Next value: a load wins over an advance; otherwise hold.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (load_val == 16'h0000) ? SEED_DEF : load_val;
      end else if (adv) begin
         state_d = lfsr_next(state_q);
      end else begin
         state_d = state_q;
      end
   end

   // State register with synchronous active-low reset to the default seed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SEED_DEF;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/col_weight_gen.sv
// Builds a pseudo-random 128-bit column with an exact number of ones, LANES positions per cycle.
module col_weight_gen #(
   parameter int          LANES    = 4,
   parameter logic [15:0] SEED_DEF = col_gen_pkg::SEED_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         seed_load,
   input  logic [15:0]  seed,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_weight,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_col,
   output logic [7:0]   out_weight,
   output logic         out_clamped
);
   import col_gen_pkg::*;

   localparam logic [6:0] LANES_C = 7'(LANES);
   localparam logic [7:0] HALF_W  = 8'd64;
   localparam logic [7:0] FULL_W  = 8'd128;

   state_t         state_q;
   mode_t          mode_q;
   logic [6:0]     rem_q;
   logic [6:0]     base_q;
   logic [6:0]     step_q;
   logic [6:0]     pos_q;
   logic [127:0]   col_q;
   logic [7:0]     weight_q;
   logic           clamped_q;
   logic           valid_q;

   logic [15:0]    lfsr_s;
   logic           accept_s;
   logic           clamp_s;
   logic [7:0]     w_s;
   logic           wide_s;
   logic [6:0]     rem_init_s;
   logic [6:0]     rem_next_s;
   logic [127:0]   fill_col_s;
   logic [6:0]     lane_idx_s [LANES];

   assign in_ready = rst_n && (state_q == IDLE);
   assign accept_s = in_valid && in_ready;

   lfsr16 #(
      .SEED_DEF (SEED_DEF)
   ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (seed_load),
      .load_val (seed),
      .adv      (accept_s),
      .state    (lfsr_s)
   );

   // Request decode: clamp the weight and pick the cheaper direction (set ones or clear ones).
   always_comb begin
      clamp_s    = (in_weight > FULL_W);
      w_s        = clamp_s ? FULL_W : in_weight;
      wide_s     = (w_s > HALF_W);
      rem_init_s = wide_s ? 7'(FULL_W - w_s) : w_s[6:0];
   end

   // One FILL step: each active lane writes the mode value at its permuted position.
   always_comb begin
      fill_col_s = col_q;
      for (int j = 0; j < LANES; j++) begin
         lane_idx_s[j] = base_q + step_q * (pos_q + 7'(j));
         fill_col_s[lane_idx_s[j]] = (7'(j) < rem_q) ? (mode_q == SET)
                                                      : fill_col_s[lane_idx_s[j]];
      end
      rem_next_s = (rem_q > LANES_C) ? (rem_q - LANES_C) : 7'd0;
   end

   // Control FSM with registered column, count and valid outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mode_q    <= SET;
         rem_q     <= 7'd0;
         base_q    <= 7'd0;
         step_q    <= 7'd0;
         pos_q     <= 7'd0;
         col_q     <= {COL_W{1'b0}};
         weight_q  <= 8'd0;
         clamped_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  clamped_q <= clamp_s;
                  weight_q  <= w_s;
                  base_q    <= lfsr_s[6:0];
                  step_q    <= {lfsr_s[13:8], 1'b1};
                  pos_q     <= 7'd0;
                  rem_q     <= rem_init_s;
                  col_q     <= wide_s ? {COL_W{1'b1}} : {COL_W{1'b0}};
                  mode_q    <= wide_s ? CLEAR : SET;
                  state_q   <= (rem_init_s == 7'd0) ? HOLD : FILL;
                  valid_q   <= (rem_init_s == 7'd0);
               end else begin
                  state_q   <= IDLE;
               end
            end
            FILL: begin
               col_q   <= fill_col_s;
               rem_q   <= rem_next_s;
               pos_q   <= pos_q + LANES_C;
               state_q <= (rem_next_s == 7'd0) ? HOLD : FILL;
               valid_q <= (rem_next_s == 7'd0);
            end
            HOLD: begin
               if (out_ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end else begin
                  state_q <= HOLD;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid   = valid_q;
   assign out_col     = col_q;
   assign out_weight  = weight_q;
   assign out_clamped = clamped_q;

endmodule

// File: doc/col_weight_gen.md
Name: col_weight_gen

Overview:
- Sequential stimulus source for the 128-bit column compressors; the counterpart of the compressor's column-to-count direction.
- Takes a requested Hamming weight and builds a pseudo-random 128-bit column containing exactly that many ones.
- Emits the column together with its expected count, so hardware-eval wrappers and benches can drive `in_col0` and check `comp_out`.
- Work is spread over several cycles and flow-controlled with valid/ready handshakes on both sides.

Parameters:
- COL_W, 128, column width; fixed at 128 by the package, not overridable.
- LANES, 4, bit positions placed per FILL cycle; must be a power of two in 1..64.
- SEED_DEF, 16'hACE1, LFSR value after reset and substitute for a zero seed.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- seed_load  in  1  load `seed` into the LFSR this cycle.
- seed  in  16  LFSR seed; zero is replaced by SEED_DEF.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when `in_valid && in_ready`.
- in_weight  in  8  requested weight; values above 128 are clamped.
- out_valid  out  1  column result valid.
- out_ready  in  1  downstream accepts the result.
- out_col  out  128  generated column.
- out_weight  out  8  exact popcount of `out_col`.
- out_clamped  out  1  set when `in_weight` exceeded 128.

Behaviour:
- Reset, synchronous on `rst_n` = 0:
  - state = IDLE, LFSR = SEED_DEF, `out_valid` = 0, `out_col` = 0, `out_weight` = 0, `out_clamped` = 0.
  - `in_ready` = 0 while `rst_n` is low.
  - Reset mid-FILL or mid-HOLD discards the request; no partial output appears.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances exactly once per accepted request.
  - `seed_load` in any state overwrites the LFSR and takes priority over the advance.
- `in_ready` = (state == IDLE).
- IDLE, on accept:
  - w = min(`in_weight`, 128); latch `out_clamped` and set `out_weight` = w.
  - If w > 64: `out_col` = all ones, mode = CLEAR, rem = 128 − w.
  - Otherwise: `out_col` = 0, mode = SET, rem = w.
  - base = lfsr[6:0]; step = {lfsr[13:8], 1'b1} (always odd); position counter i = 0.
  - Next state is HOLD if rem = 0, otherwise FILL.
- FILL:
  - Lane j (0..LANES−1) is active when j < rem.
  - An active lane writes the mode value (1 for SET, 0 for CLEAR) at index (base + step·(i+j)) mod 128.
  - Because step is odd, indices form a permutation of 0..127, so no position is touched twice and every write changes a bit.
  - rem −= min(LANES, rem); i += LANES.
  - Go to HOLD when rem reaches 0.
- HOLD:
  - `out_valid` = 1; `out_col`, `out_weight` and `out_clamped` are stable.
  - On `out_ready` go to IDLE and drop `out_valid` next cycle.
  - Outputs keep their last value in IDLE.
- Latency: accept at edge T gives `out_valid` high from cycle T+1+ceil(m/LANES), where m = min(w, 128−w). Worst case is 64/LANES + 1 cycles.
- Arithmetic: index math is 7-bit modulo-128 wrap; rem is 7 bits.
- Simultaneous `out_ready` in HOLD and `in_valid`: the new request is not accepted until the IDLE cycle (one bubble).

Decomposition:
- Package `col_gen_pkg`:
  - COL_W = 128, CNT_W = 8, LFSR_W = 16.
  - LFSR tap constant, SEED_DEF.
  - State enum {IDLE, FILL, HOLD}.
  - Mode enum {SET, CLEAR}.
- Sub-module `lfsr16`: inputs `clk`, `rst_n`, `load`, `load_val`, `adv`; output `state`; handles the zero-seed substitution.
- Lane index computation and bit update stay in the top module.

Test Plan:
- Weight 0, seed 0xACE1 → `out_col` = 0, `out_weight` = 0, `out_valid` at T+1.
- Weight 128 → `out_col` = all ones, `out_valid` at T+1.
- Weight 64, LANES = 4 → popcount(`out_col`) = 64, `out_valid` at T+17; weight 100 → popcount 100 via CLEAR, `out_valid` at T+8.
- Weight 200 → `out_clamped` = 1, `out_weight` = 128, `out_col` all ones.
- Weight 37, `out_ready` held low 10 cycles → `out_col` stable, `in_ready` = 0 throughout; accept completes on the first `out_ready`.
- Reproducibility and reset:
  - Load seed 0x1234, request 37; reload 0x1234, request 37 → identical `out_col`.
  - Seed 0 → same columns as seed 0xACE1.
  - Reset asserted on the 3rd FILL cycle → `out_valid` stays 0 and the next request completes normally.
